// File: rtl/fp_mult_pkg.sv
// fp_mult_pkg - shared types and helpers for the sequential FP multiplier.
// Holds the controller state encoding, the operand classes and the
// exponent helpers that depend only on the exponent width.
package fp_mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MULT = 2'd1,
      NORM = 2'd2,
      DONE = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      ZERO   = 2'd0,
      NORMAL = 2'd1,
      INF    = 2'd2,
      NAN    = 2'd3
   } opclass_t;

   // Exponent bias for an e-bit exponent field: 2^(e-1)-1.
   function automatic int unsigned expBias(input int unsigned e);
      return (32'd1 << (e - 32'd1)) - 32'd1;
   endfunction

   // All-ones exponent value for an e-bit exponent field: 2^e-1.
   function automatic int unsigned expOnes(input int unsigned e);
      return (32'd1 << e) - 32'd1;
   endfunction

endpackage

// File: rtl/fp_sig_shiftadd.sv
// fp_sig_shiftadd - iterative (M+1)x(M+1) unsigned significand multiplier.
// One partial product per cycle: the multiplicand is added into the
// accumulator when the current multiplier LSB is set, then the multiplicand
// moves left and the multiplier moves right. Takes exactly M+1 busy cycles.
// done_o is high during the final iteration; the product is complete on
// the clock edge that ends that cycle. LO trims product bits the caller
// never looks at.
module fp_sig_shiftadd #(
   parameter int M  = 8,
   parameter int LO = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_i,
   input  logic [M:0]       a_i,
   input  logic [M:0]       b_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [2*M+1:LO]  prod_o
);

   localparam int CW = $clog2(M + 1);

   logic            busy_q, busy_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2*M+1:0]  acc_q, acc_d;
   logic [2*M+1:0]  mcand_q, mcand_d;
   logic [M:0]      mplier_q, mplier_d;
   logic            lastIter;

   assign lastIter = (cnt_q == CW'(M));
   assign busy_o   = busy_q;
   assign done_o   = busy_q && lastIter;
   assign prod_o   = acc_q[2*M+1:LO];

   // Load operands on start, otherwise perform one add-and-shift step per busy cycle.
   always_comb begin
      busy_d   = busy_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      if (start_i) begin
         busy_d   = 1'b1;
         cnt_d    = '0;
         acc_d    = '0;
         mcand_d  = {{(M+1){1'b0}}, a_i};
         mplier_d = b_i;
      end else if (busy_q) begin
         if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
         end
         mcand_d  = {mcand_q[2*M:0], 1'b0};
         mplier_d = {1'b0, mplier_q[M:1]};
         cnt_d    = cnt_q + CW'(1);
         if (lastIter) begin
            busy_d = 1'b0;
         end
      end
   end

   // Datapath registers; reset abandons any product in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy_q   <= 1'b0;
         cnt_q    <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
      end else begin
         busy_q   <= busy_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
      end
   end

endmodule

// File: rtl/fp_mult_seq.sv
// fp_mult_seq - multicycle floating-point multiplier, format
// sign | exponent (E bits, bias 2^(E-1)-1) | fraction (M bits, hidden 1).
// Valid/ready on both sides. Special operands bypass the significand
// multiplier and go straight to DONE. out_valid is registered one cycle
// after entering DONE, so results are always stable when it rises.
// Optional macro FP_MULT_RNE_EN: round to nearest even in NORM instead of
// truncating.
module fp_mult_seq
   import fp_mult_pkg::*;
#(
   parameter int E = 8,
   parameter int M = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [E+M:0]  X,
   input  logic [E+M:0]  Y,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [E+M:0]  result,
   output logic          zero,
   output logic          underflow,
   output logic          overflow,
   output logic          nan
);

   localparam logic [E+1:0] BIAS_X   = (E+2)'(expBias(E));
   localparam logic [E+1:0] ONES_X   = (E+2)'(expOnes(E));
   localparam logic [E-1:0] EXP_ONES = E'(expOnes(E));
`ifdef FP_MULT_RNE_EN
   localparam int PROD_LO = 0;
`else
   localparam int PROD_LO = M;
`endif

   function automatic opclass_t classify(input logic [E-1:0] ex, input logic [M-1:0] fr);
      if (ex == '0) begin
         return ZERO;
      end else if (ex == EXP_ONES) begin
         return (fr == '0) ? INF : NAN;
      end
      return NORMAL;
   endfunction

   logic              xSign, ySign, opSign;
   logic [E-1:0]      xExp, yExp;
   logic [M-1:0]      xFrac, yFrac;
   opclass_t          xClass, yClass;
   logic              anyNan, anyInf, anyZero;

   state_t            state_q, state_d;
   logic              sign_q, sign_d;
   logic [E+1:0]      exp_q, exp_d;
   logic              outValid_q, outValid_d;
   logic [E+M:0]      result_q, result_d;
   logic              zero_q, zero_d;
   logic              underflow_q, underflow_d;
   logic              overflow_q, overflow_d;
   logic              nan_q, nan_d;

   logic              sigStart, sigBusy, sigDone;
   logic [2*M+1:PROD_LO] sigProd;

   logic [E+1:0]      normExp;
   logic [M-1:0]      normFrac;
   logic              normOverflow, normUnderflow;
`ifdef FP_MULT_RNE_EN
   logic              guardBit, stickyBit, roundCarry;
`endif

   assign {xSign, xExp, xFrac} = X;
   assign {ySign, yExp, yFrac} = Y;
   assign opSign  = xSign ^ ySign;
   assign xClass  = classify(xExp, xFrac);
   assign yClass  = classify(yExp, yFrac);
   assign anyNan  = (xClass == NAN) || (yClass == NAN) ||
                    ((xClass == ZERO) && (yClass == INF)) ||
                    ((xClass == INF) && (yClass == ZERO));
   assign anyInf  = (xClass == INF) || (yClass == INF);
   assign anyZero = (xClass == ZERO) || (yClass == ZERO);

   assign in_ready  = (state_q == IDLE) && !sigBusy;
   assign out_valid = outValid_q;
   assign result    = result_q;
   assign zero      = zero_q;
   assign underflow = underflow_q;
   assign overflow  = overflow_q;
   assign nan       = nan_q;

   fp_sig_shiftadd #(
      .M  (M),
      .LO (PROD_LO)
   ) uSig (
      .clk     (clk),
      .reset   (reset),
      .start_i (sigStart),
      .a_i     ({1'b1, xFrac}),
      .b_i     ({1'b1, yFrac}),
      .busy_o  (sigBusy),
      .done_o  (sigDone),
      .prod_o  (sigProd)
   );

   // Normalise the finished product, optionally round, then range-check the exponent.
   always_comb begin
      normExp = exp_q + {{(E+1){1'b0}}, sigProd[2*M+1]};
      if (sigProd[2*M+1]) begin
         normFrac = sigProd[2*M:M+1];
      end else begin
         normFrac = sigProd[2*M-1:M];
      end
`ifdef FP_MULT_RNE_EN
      if (sigProd[2*M+1]) begin
         guardBit  = sigProd[M];
         stickyBit = |sigProd[M-1:0];
      end else begin
         guardBit  = sigProd[M-1];
         stickyBit = |sigProd[M-2:0];
      end
      roundCarry = 1'b0;
      if (guardBit && (stickyBit || normFrac[0])) begin
         {roundCarry, normFrac} = {1'b0, normFrac} + {{M{1'b0}}, 1'b1};
      end
      if (roundCarry) begin
         normExp = normExp + {{(E+1){1'b0}}, 1'b1};
      end
`endif
      normOverflow  = !normExp[E+1] && (normExp >= ONES_X);
      normUnderflow = normExp[E+1] || (normExp == '0);
   end

   // Controller: accept and classify, sequence the multiplier, normalise, hold the result.
   always_comb begin
      state_d     = state_q;
      sign_d      = sign_q;
      exp_d       = exp_q;
      outValid_d  = outValid_q;
      result_d    = result_q;
      zero_d      = zero_q;
      underflow_d = underflow_q;
      overflow_d  = overflow_q;
      nan_d       = nan_q;
      sigStart    = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid && in_ready) begin
               sign_d      = opSign;
               exp_d       = {2'b00, xExp} + {2'b00, yExp} - BIAS_X;
               zero_d      = 1'b0;
               underflow_d = 1'b0;
               overflow_d  = 1'b0;
               nan_d       = 1'b0;
               if (anyNan) begin
                  result_d = {1'b0, EXP_ONES, 1'b1, {(M-1){1'b0}}};
                  nan_d    = 1'b1;
                  state_d  = DONE;
               end else if (anyInf) begin
                  result_d   = {opSign, EXP_ONES, {M{1'b0}}};
                  overflow_d = 1'b1;
                  state_d    = DONE;
               end else if (anyZero) begin
                  result_d = {opSign, {(E+M){1'b0}}};
                  zero_d   = 1'b1;
                  state_d  = DONE;
               end else begin
                  sigStart = 1'b1;
                  state_d  = MULT;
               end
            end
         end
         MULT: begin
            if (sigDone) begin
               state_d = NORM;
            end
         end
         NORM: begin
            state_d = DONE;
            if (normOverflow) begin
               result_d   = {sign_q, EXP_ONES, {M{1'b0}}};
               overflow_d = 1'b1;
            end else if (normUnderflow) begin
               result_d    = {sign_q, {(E+M){1'b0}}};
               underflow_d = 1'b1;
            end else begin
               result_d = {sign_q, normExp[E-1:0], normFrac};
            end
         end
         DONE: begin
            if (!outValid_q) begin
               outValid_d = 1'b1;
            end else if (out_ready) begin
               outValid_d = 1'b0;
               state_d    = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; reset abandons any operation in progress.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         sign_q      <= 1'b0;
         exp_q       <= '0;
         outValid_q  <= 1'b0;
         result_q    <= '0;
         zero_q      <= 1'b0;
         underflow_q <= 1'b0;
         overflow_q  <= 1'b0;
         nan_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         sign_q      <= sign_d;
         exp_q       <= exp_d;
         outValid_q  <= outValid_d;
         result_q    <= result_d;
         zero_q      <= zero_d;
         underflow_q <= underflow_d;
         overflow_q  <= overflow_d;
         nan_q       <= nan_d;
      end
   end

endmodule

// File: doc/fp_mult_seq.md
Name: fp_mult_seq

Overview:
Multicycle, parametrised floating-point multiplier. It is the sequential successor to the combinational FP multiplier, with the same custom format: sign | exponent (E bits, bias 2^(E-1)-1) | fraction (M bits, hidden 1).
- The significand product is computed by a shift-add datapath, one partial product per cycle, instead of a full-width array multiplier.
- Operands and results use valid/ready handshakes so the block can sit in a streaming datapath with back-pressure.
- Outputs carry the zero, underflow, overflow and nan flags.

Parameters:
E, 8, exponent field width (>=3)
M, 8, fraction field width (>=2)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  operand pair valid
in_ready  out  1  block can accept operands (high only in IDLE)
X  in  E+M+1  operand A
Y  in  E+M+1  operand B
out_valid  out  1  result and flags valid
out_ready  in  1  consumer accepts result
result  out  E+M+1  product
zero  out  1  result is exact zero from a zero operand
underflow  out  1  biased exponent <= 0 after normalisation
overflow  out  1  biased exponent >= 2^E-1 after normalisation
nan  out  1  invalid result

Behaviour:
- Reset, asynchronous, to IDLE: in_ready=1, out_valid=0, result=0, all flags 0. Reset mid-operation abandons the op; no output is produced for it.
- States: IDLE -> MULT -> NORM -> DONE -> IDLE.
- Special-case path: IDLE -> DONE directly.
- IDLE:
  - On in_valid&in_ready, register sign = Xs^Ys.
  - Register exponent sum Ex+Ey-bias as signed E+2 bits.
  - Register significands {1,Xm} and {1,Ym}, M+1 bits each.
  - Classify the operands and pick the next state.
- Classification:
  - exp==0 means zero. Denormals are flushed to zero.
  - exp all-ones with frac==0 means inf; with frac!=0 means NaN.
- Special results (go straight to DONE):
  - Any NaN operand, or zero*inf: result={0,all-ones,1000..0}, nan=1.
  - Inf operand (other operand non-zero, non-NaN): result={sign,all-ones,0}, overflow=1.
  - Zero operand: result={sign,0,0}, zero=1.
- MULT:
  - Iteration counter runs 0..M.
  - Each cycle: if the multiplier LSB is 1, add the multiplicand to the 2M+2-bit accumulator; then shift.
  - Exactly M+1 cycles.
- NORM (1 cycle):
  - If product bit 2M+1 is set, take fraction from bits [2M:M+1] and add 1 to the exponent.
  - Otherwise take bits [2M-1:M].
  - Default rounding is truncation.
  - Then check range:
    - exp >= 2^E-1: overflow=1, result={sign,all-ones,0}.
    - exp <= 0: underflow=1, result={sign,0,0}, zero=0.
- DONE:
  - out_valid=1; result and flags are held stable until out_ready.
  - The cycle with out_valid&out_ready returns to IDLE.
  - in_ready goes high on the next cycle; there is no same-cycle accept.
- Latency, counting the accept edge as k:
  - Normal path: out_valid rises after edge k+M+3.
  - Special path: out_valid rises after edge k+1.
- Flags are mutually exclusive. Flags are only meaningful while out_valid=1.
- X/Y changes while not in IDLE are ignored.

Optional Feature:
FP_MULT_RNE_EN
- Defined: NORM rounds to nearest, ties to even, using the guard bit and a sticky OR of the discarded bits.
  - A fraction carry-out sets the fraction to 0 and increments the exponent.
  - The range check happens after rounding.
  - NORM stays a single cycle.
- Undefined: truncation, and no rounding logic is generated.

Decomposition:
- Package fp_mult_pkg holds:
  - state enum {IDLE, MULT, NORM, DONE};
  - the operand-class enum {ZERO, NORMAL, INF, NAN};
  - parameterised helper functions for bias and all-ones exponent.
- One sub-module, fp_sig_shiftadd: M+1-bit iterative significand multiplier with start/busy/done.
  - The top FSM sequences it and owns exponent, sign, normalisation and flags.

Test Plan (E=8, M=8):
- 0x07F80 (1.5) * 0x08000 (2.0) -> result 0x08080 (3.0), no flags, out_valid exactly M+3=11 cycles after accept. Sign variant 0x17F80*0x08000 -> 0x18080.
- 0x0F000*0x0F000 -> overflow=1, result 0x0FF00. 0x01000*0x01000 -> underflow=1, result 0x00000, zero=0.
- 0x00000*0x0FF00 (zero*inf) -> nan=1, result 0x0FF80, out_valid 1 cycle after accept. 0x00000*0x07F80 -> zero=1, result 0x00000.
- 0x07F83*0x07F83 -> truncation build 0x08024; with FP_MULT_RNE_EN 0x08025.
- Back-pressure: hold out_ready=0 for 5 cycles in DONE -> result/flags stable, in_ready=0. Then release -> in_ready=1 the following cycle, and back-to-back ops succeed.
- Assert reset during MULT -> all outputs 0 immediately (async), in_ready=1 after release, and the next op 0x07F80*0x08000 gives 0x08080.
